// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding and word geometry.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with byte-lane writes, combinational read and a
// synchronous clear of every word while reset is high.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  we,
    input  logic [AW-1:0]         index,
    input  logic [31:0]           wdata,
    input  logic [WORD_BYTES-1:0] be,
    output logic [31:0]           rdata
);

    logic [31:0] mem_r [DEPTH];

    // Storage: clear on reset, otherwise update only the enabled byte lanes.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem_r[w] <= 32'h0000_0000;
            end
        end else if (we) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (be[b]) begin
                    mem_r[index][b*BYTE_W +: BYTE_W] <= wdata[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    assign rdata = mem_r[index];

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready memory responder: accepts one load/store, waits WAIT_STATES
// cycles, performs the access on entry to RESP and holds the response.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW       = $clog2(DEPTH);
    localparam int          CW       = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [31:0] SPAN     = 32'(DEPTH * WORD_BYTES);
    localparam logic [CW-1:0] CNT_LOAD = CW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic          ready_r;
    logic          enter_resp_s;
    logic          accept_s;

    logic          cap_we_r;
    logic [31:0]   cap_addr_r, cap_wdata_r;
    logic [3:0]    cap_be_r;

    logic          acc_we_s;
    logic [31:0]   acc_addr_s, acc_wdata_s;
    logic [3:0]    acc_be_s;
    logic [32:0]   off_wide_s;
    logic          acc_err_s;
    logic          arr_we_s;
    logic [31:0]   arr_rdata_s;

    logic          rsp_valid_r, rsp_err_r;
    logic [31:0]   rsp_rdata_r;

    assign req_ready = ready_r & ~reset;
    assign accept_s  = req_valid & req_ready;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

    // With zero wait states the access happens on the acceptance edge, so the live request is used.
    assign acc_we_s    = (state_r == IDLE) ? req_we    : cap_we_r;
    assign acc_addr_s  = (state_r == IDLE) ? req_addr  : cap_addr_r;
    assign acc_wdata_s = (state_r == IDLE) ? req_wdata : cap_wdata_r;
    assign acc_be_s    = (state_r == IDLE) ? req_be    : cap_be_r;

    // Bit 32 of the widened offset flags an address below BASE_ADDR.
    assign off_wide_s = {1'b0, acc_addr_s} - {1'b0, BASE_ADDR};
    assign acc_err_s  = (acc_addr_s[1:0] != 2'b00) || off_wide_s[32] || (off_wide_s[31:0] >= SPAN);
    assign arr_we_s   = enter_resp_s & acc_we_s & ~acc_err_s;

    dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
        .clock (clock),
        .reset (reset),
        .we    (arr_we_s),
        .index (off_wide_s[AW+1:2]),
        .wdata (acc_wdata_s),
        .be    (acc_be_s),
        .rdata (arr_rdata_s)
    );

    // Next-state and wait-counter logic.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        enter_resp_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (WAIT_STATES == 0) begin
                        state_s      = RESP;
                        enter_resp_s = 1'b1;
                    end else begin
                        state_s = WAIT;
                        cnt_s   = CNT_LOAD;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == CW'(0)) begin
                    state_s      = RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    cnt_s = cnt_r - CW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CW'(0);
            end
        endcase
    end

    // State, counter and registered ready.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= CW'(0);
            ready_r <= 1'b1;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            ready_r <= (state_s == IDLE);
        end
    end

    // Request capture on acceptance; inputs need not be held afterwards.
    always_ff @(posedge clock) begin
        if (reset) begin
            cap_we_r    <= 1'b0;
            cap_addr_r  <= 32'h0000_0000;
            cap_wdata_r <= 32'h0000_0000;
            cap_be_r    <= 4'h0;
        end else if (accept_s) begin
            cap_we_r    <= req_we;
            cap_addr_r  <= req_addr;
            cap_wdata_r <= req_wdata;
            cap_be_r    <= req_be;
        end
    end

    // Response registers: loaded on entry to RESP, held until the handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end else if (enter_resp_s) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= acc_err_s;
            rsp_rdata_r <= (acc_err_s || acc_we_s) ? 32'h0000_0000 : arr_rdata_s;
        end else if (rsp_valid_r && rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: a WAIT_STATES=2 instance (a_*) and a WAIT_STATES=0 instance (b_*).
module tb_dmem_responder;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
    logic [3:0]  a_req_be;
    logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
    logic [3:0]  b_req_be;

    int n_vec = 0;
    int n_err = 0;

    dmem_responder #(.DEPTH(1024), .WAIT_STATES(2), .BASE_ADDR(32'h0000_0000)) u_dut (
        .clock(clock), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    dmem_responder #(.DEPTH(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0000_0000)) u_dut0 (
        .clock(clock), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    // lat = number of edges after the acceptance edge until the edge where the core sees rsp_valid.
    task automatic txn(input bit sel, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output int lat, output logic [31:0] rdata,
                       output logic err, output time t_acc);
        int guard;
        if (sel) begin
            b_req_we = we; b_req_addr = addr; b_req_wdata = wdata; b_req_be = be;
            b_req_valid = 1'b1; b_rsp_ready = 1'b1;
        end else begin
            a_req_we = we; a_req_addr = addr; a_req_wdata = wdata; a_req_be = be;
            a_req_valid = 1'b1; a_rsp_ready = 1'b1;
        end
        guard = 0;
        while (((sel ? b_req_ready : a_req_ready) !== 1'b1) && guard < 50) begin
            @(posedge clock); #1; guard++;
        end
        @(posedge clock);
        t_acc = $time;
        #1;
        if (sel) begin
            b_req_valid = 1'b0; b_req_addr = 32'hFFFF_FFFF; b_req_wdata = $urandom; b_req_we = ~we;
        end else begin
            a_req_valid = 1'b0; a_req_addr = 32'hFFFF_FFFF; a_req_wdata = $urandom; a_req_we = ~we;
        end
        lat = 0;
        for (int k = 0; k < 50; k++) begin
            if ((sel ? b_rsp_valid : a_rsp_valid) === 1'b1) begin
                lat = k + 1;
                break;
            end
            @(posedge clock); #1;
        end
        rdata = sel ? b_rsp_rdata : a_rsp_rdata;
        err   = sel ? b_rsp_err : a_rsp_err;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        if (a_req_ready !== 1'b0) begin $display("FAIL reset_req_ready: got %b expected 0", a_req_ready); n_err++; end
        n_vec++;
        if (a_rsp_valid !== 1'b0) begin $display("FAIL reset_rsp_valid: got %b expected 0", a_rsp_valid); n_err++; end
        n_vec++;
        if (a_rsp_rdata !== 32'h0) begin $display("FAIL reset_rsp_rdata: got %h expected 0", a_rsp_rdata); n_err++; end
        n_vec++;
        if (a_rsp_err !== 1'b0) begin $display("FAIL reset_rsp_err: got %b expected 0", a_rsp_err); n_err++; end
        n_vec++;
        reset = 1'b0;
        #1;
        if (a_req_ready !== 1'b1) begin $display("FAIL post_reset_ready: got %b expected 1", a_req_ready); n_err++; end
        n_vec++;
        if (b_req_ready !== 1'b1) begin $display("FAIL post_reset_ready0: got %b expected 1", b_req_ready); n_err++; end
        n_vec++;
    endtask

    task automatic test_store_load();
        int lat; logic [31:0] rd; logic er; time t;
        txn(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, lat, rd, er, t);
        if (lat !== 3) begin $display("FAIL store_latency: got %0d expected 3", lat); n_err++; end
        n_vec++;
        if (rd !== 32'h0 || er !== 1'b0) begin $display("FAIL store_rsp: got %h/%b expected 0/0", rd, er); n_err++; end
        n_vec++;
        txn(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er, t);
        if (lat !== 3) begin $display("FAIL load_latency: got %0d expected 3", lat); n_err++; end
        n_vec++;
        if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin $display("FAIL load_0x10: got %h/%b expected deadbeef/0", rd, er); n_err++; end
        n_vec++;
    endtask

    task automatic test_byte_enable();
        int lat; logic [31:0] rd; logic er; time t;
        txn(1'b0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, lat, rd, er, t);
        txn(1'b0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, lat, rd, er, t);
        txn(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, lat, rd, er, t);
        if (rd !== 32'h11BB_33DD || er !== 1'b0) begin $display("FAIL byte_enable: got %h/%b expected 11bb33dd/0", rd, er); n_err++; end
        n_vec++;
        txn(1'b0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, lat, rd, er, t);
        if (er !== 1'b0) begin $display("FAIL be_zero_err: got %b expected 0", er); n_err++; end
        n_vec++;
        txn(1'b0, 1'b0, 32'h20, 32'h0, 4'hF, lat, rd, er, t);
        if (rd !== 32'h11BB_33DD) begin $display("FAIL be_zero_nowrite: got %h expected 11bb33dd", rd); n_err++; end
        n_vec++;
    endtask

    task automatic test_errors();
        int lat; logic [31:0] rd; logic er; time t;
        txn(1'b0, 1'b0, 32'h22, 32'h0, 4'hF, lat, rd, er, t);
        if (rd !== 32'h0 || er !== 1'b1) begin $display("FAIL misaligned_load: got %h/%b expected 0/1", rd, er); n_err++; end
        n_vec++;
        txn(1'b0, 1'b0, 32'h1000, 32'h0, 4'hF, lat, rd, er, t);
        if (rd !== 32'h0 || er !== 1'b1) begin $display("FAIL range_load: got %h/%b expected 0/1", rd, er); n_err++; end
        n_vec++;
        if (lat !== 3) begin $display("FAIL error_latency: got %0d expected 3", lat); n_err++; end
        n_vec++;
        txn(1'b0, 1'b0, 32'hFFC, 32'h0, 4'hF, lat, rd, er, t);
        if (rd !== 32'h0 || er !== 1'b0) begin $display("FAIL last_word_load: got %h/%b expected 0/0", rd, er); n_err++; end
        n_vec++;
        txn(1'b0, 1'b1, 32'h23, 32'h5555_5555, 4'hF, lat, rd, er, t);
        if (rd !== 32'h0 || er !== 1'b1) begin $display("FAIL misaligned_store: got %h/%b expected 0/1", rd, er); n_err++; end
        n_vec++;
        txn(1'b0, 1'b0, 32'h20, 32'h0, 4'hF, lat, rd, er, t);
        if (rd !== 32'h11BB_33DD || er !== 1'b0) begin $display("FAIL reload_0x20: got %h/%b expected 11bb33dd/0", rd, er); n_err++; end
        n_vec++;
    endtask

    task automatic test_hold();
        int lat; logic [31:0] rd; logic er; time t; bit seen;
        a_rsp_ready = 1'b0;
        a_req_we = 1'b0; a_req_addr = 32'h10; a_req_be = 4'hF; a_req_valid = 1'b1;
        for (int g = 0; g < 50 && a_req_ready !== 1'b1; g++) begin @(posedge clock); #1; end
        @(posedge clock); #1;
        a_req_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (a_rsp_valid === 1'b1) begin seen = 1'b1; break; end
            @(posedge clock); #1;
        end
        if (seen !== 1'b1) begin $display("FAIL hold_rsp_timeout: got %b expected 1", seen); n_err++; end
        n_vec++;
        for (int i = 0; i < 5; i++) begin
            a_req_valid = (i % 2 == 0); a_req_we = 1'b1; a_req_addr = 32'h10; a_req_wdata = 32'h0;
            if (a_req_ready !== 1'b0) begin $display("FAIL hold_req_ready[%0d]: got %b expected 0", i, a_req_ready); n_err++; end
            n_vec++;
            if (a_rsp_valid !== 1'b1 || a_rsp_err !== 1'b0) begin $display("FAIL hold_valid_err[%0d]: got %b/%b expected 1/0", i, a_rsp_valid, a_rsp_err); n_err++; end
            n_vec++;
            if (a_rsp_rdata !== 32'hDEAD_BEEF) begin $display("FAIL hold_rdata[%0d]: got %h expected deadbeef", i, a_rsp_rdata); n_err++; end
            n_vec++;
            @(posedge clock); #1;
        end
        a_req_valid = 1'b0;
        a_rsp_ready = 1'b1;
        @(posedge clock); #1;
        if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1) begin $display("FAIL hold_release: got valid=%b ready=%b expected 0/1", a_rsp_valid, a_req_ready); n_err++; end
        n_vec++;
        txn(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, lat, rd, er, t);
        if (rd !== 32'hDEAD_BEEF) begin $display("FAIL hold_pulses_ignored: got %h expected deadbeef", rd); n_err++; end
        n_vec++;
    endtask

    task automatic test_zero_wait();
        int lat; logic [31:0] rd; logic er; time t1, t2;
        txn(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, lat, rd, er, t1);
        if (lat !== 1) begin $display("FAIL zw_load_latency: got %0d expected 1", lat); n_err++; end
        n_vec++;
        if (rd !== 32'h0 || er !== 1'b0) begin $display("FAIL zw_empty_load: got %h/%b expected 0/0", rd, er); n_err++; end
        n_vec++;
        txn(1'b1, 1'b1, 32'h40, 32'h1234_5678, 4'hF, lat, rd, er, t1);
        txn(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, lat, rd, er, t2);
        if (rd !== 32'h1234_5678 || lat !== 1) begin $display("FAIL zw_store_load: got %h lat %0d expected 12345678 lat 1", rd, lat); n_err++; end
        n_vec++;
        if (t2 - t1 !== 20) begin $display("FAIL zw_back_to_back: got %0t expected 20", t2 - t1); n_err++; end
        n_vec++;
    endtask

    task automatic test_reset_abort();
        int lat; logic [31:0] rd; logic er; time t;
        a_req_we = 1'b1; a_req_addr = 32'h30; a_req_wdata = 32'hCAFE_F00D; a_req_be = 4'hF; a_req_valid = 1'b1;
        for (int g = 0; g < 50 && a_req_ready !== 1'b1; g++) begin @(posedge clock); #1; end
        @(posedge clock); #1;
        a_req_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1) begin $display("FAIL abort_idle: got valid=%b ready=%b expected 0/1", a_rsp_valid, a_req_ready); n_err++; end
        n_vec++;
        @(posedge clock); #1;
        if (a_rsp_valid !== 1'b0) begin $display("FAIL abort_no_rsp: got %b expected 0", a_rsp_valid); n_err++; end
        n_vec++;
        txn(1'b0, 1'b0, 32'h30, 32'h0, 4'hF, lat, rd, er, t);
        if (rd !== 32'h0 || er !== 1'b0) begin $display("FAIL abort_no_write: got %h/%b expected 0/0", rd, er); n_err++; end
        n_vec++;
        txn(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, lat, rd, er, t);
        if (rd !== 32'h0) begin $display("FAIL abort_cleared: got %h expected 0", rd); n_err++; end
        n_vec++;
    endtask

    initial begin
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = 32'h0; a_req_wdata = 32'h0; a_req_be = 4'h0; a_rsp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = 32'h0; b_req_wdata = 32'h0; b_req_be = 4'h0; b_rsp_ready = 1'b0;
        reset = 1'b1;
        test_reset();
        test_store_load();
        test_byte_enable();
        test_errors();
        test_hold();
        test_zero_wait();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
